conv_window_ctrl: RTL
=====================

# conv_window_ctrl

Sequencing controller for the convolution line-buffer datapath (chains of variable-length shift registers feeding a K×K window). Accepts a raster-order pixel stream for one frame, drives the shift-enable and synchronous-clear of every shift register in the chain, tracks row/column position, and flags each cycle on which the K×K window holds a fully valid, in-image neighbourhood. Sits between the frame input interface and the conv MAC array in each LeNet convolution layer.

## Interface
- IMG_W, 28, frame width in pixels (≥ K)
- IMG_H, 28, frame height in pixels (≥ K)
- K, 5, kernel size; line buffers hold K-1 rows
- clk  input  1  system clock, all logic on rising edge
- global_rst_n  input  1  asynchronous, active-low reset
- i_start  input  1  single-cycle frame start request
- i_abort  input  1  synchronous abort of current frame
- i_pix_valid  input  1  pixel present on datapath input this cycle
- o_ready  output  1  controller accepts pixels (state RUN)
- o_sr_ce  output  1  shift enable to every shift register in the chain
- o_sr_rst  output  1  synchronous clear to every shift register
- o_win_valid  output  1  window contents valid this cycle
- o_win_row  output  $clog2(IMG_H)  output-map row of current window
- o_win_col  output  $clog2(IMG_W)  output-map column of current window
- o_busy  output  1  state ≠ IDLE
- o_done  output  1  one-cycle frame-complete pulse

## Operation
- States: IDLE, CLEAR, RUN, DONE.
- IDLE: i_start → CLEAR. i_start in any other state ignored.
- CLEAR: one cycle, o_sr_rst=1; row/col counters zeroed; → RUN.
- RUN: o_ready=1. Pixel accepted when i_pix_valid && o_ready; o_sr_ce = i_pix_valid && (state==RUN), combinational.
- Per accepted pixel: col increments; col==IMG_W-1 wraps to 0 and row increments. Accepting pixel (IMG_H-1, IMG_W-1) → DONE.
- Window valid for accepted pixel (row,col) iff row ≥ K-1 and col ≥ K-1; o_win_row=row-(K-1), o_win_col=col-(K-1).
- Windows per frame: (IMG_W-K+1)·(IMG_H-K+1); 576 at defaults. Columns 0..K-2 of each row never produce windows (horizontal wrap-around suppressed).
- DONE: o_done=1 for one cycle; → IDLE.
- i_abort in CLEAR/RUN/DONE: → IDLE next cycle, o_sr_rst=1 that cycle, pending o_win_valid suppressed, o_done not asserted. i_abort has priority over i_pix_valid; pixel in the same cycle not accepted (o_sr_ce=0). In IDLE, i_abort ignored.
- i_pix_valid outside RUN: no effect on counters or shift registers.

## Timing
- Reset (global_rst_n=0, async): state IDLE, counters 0; o_ready, o_sr_ce, o_sr_rst, o_win_valid, o_busy, o_done = 0; o_win_row/col = 0. Reset mid-frame discards frame; shift-register contents cleared by their own reset.
- i_start at cycle T → o_sr_rst at T+1 → o_ready first at T+2.
- Pixel accepted at cycle T → o_win_valid, o_win_row, o_win_col registered, valid at T+1 (shift registers have captured the pixel). o_win_valid low on cycles with no acceptance; row/col hold last value.
- Last pixel at T → final o_win_valid and o_done both at T+1; o_busy=0 and new i_start accepted from T+2.
- Gaps in i_pix_valid stall everything; no minimum rate.

## Configuration
- CONV_WIN_CTRL_ERR_EN defined: extra output o_err (1 bit), sticky, set when i_pix_valid=1 while o_ready=0 in any state except IDLE; cleared only by global_rst_n or by i_start accepted in IDLE; reset value 0.
- Undefined: no o_err port, pixels outside RUN silently dropped.

## Test plan
- Defaults, i_start then 784 back-to-back pixels → o_sr_rst one cycle at T+1; first o_win_valid (row 0, col 0) one cycle after pixel index 116 accepted; exactly 576 windows in raster order; last (23,23) coincident with o_done.
- Same frame with i_pix_valid random 50% duty → identical window sequence, o_sr_ce count = 784, no windows on idle cycles.
- i_abort after pixel 300 → IDLE next cycle, o_sr_rst=1, no o_done; new i_start then full frame → 576 windows from (0,0).
- global_rst_n low mid-frame → all outputs 0 immediately; next frame completes normally.
- i_start pulsed during RUN and DONE → ignored, window count unchanged; i_start the cycle after o_done → accepted.
- CONV_WIN_CTRL_ERR_EN defined, i_pix_valid during CLEAR → o_err=1 and held through frame; cleared by next accepted i_start.

Source files
------------

// File: rtl/conv_window_ctrl.sv
// rtl/conv_window_ctrl.sv - line-buffer sequencing and KxK window-valid tracking for one raster frame
// Optional sticky protocol-error flag o_err when CONV_WIN_CTRL_ERR_EN is defined.
module conv_window_ctrl #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 5
) (
  input  logic                       clk,
  input  logic                       global_rst_n,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic                       i_pix_valid,
  output logic                       o_ready,
  output logic                       o_sr_ce,
  output logic                       o_sr_rst,
  output logic                       o_win_valid,
  output logic [$clog2(IMG_H)-1:0]   o_win_row,
  output logic [$clog2(IMG_W)-1:0]   o_win_col,
  output logic                       o_busy,
  output logic                       o_done
`ifdef CONV_WIN_CTRL_ERR_EN
  ,
  output logic                       o_err
`endif
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] win_row_q, win_row_d;
  logic [CW-1:0] win_col_q, win_col_d;
  logic          win_valid_q, win_valid_d;

  logic abort_eff;
  logic accept;
  logic last_col;
  logic last_row;
  logic in_window;

`ifdef CONV_WIN_CTRL_ERR_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    win_valid_d = 1'b0;

    // Abort outranks everything, including a pixel offered in the same cycle.
    abort_eff = i_abort && (state_q != S_IDLE);
    accept    = i_pix_valid && (state_q == S_RUN) && !i_abort;
    last_col  = (col_q == CW'(IMG_W - 1));
    last_row  = (row_q == RW'(IMG_H - 1));
    in_window = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));

    o_ready     = (state_q == S_RUN);
    o_busy      = (state_q != S_IDLE);
    o_sr_ce     = accept;
    o_sr_rst    = (state_q == S_CLEAR) || abort_eff;
    o_done      = (state_q == S_DONE) && !abort_eff;
    o_win_valid = win_valid_q && !abort_eff;
    o_win_row   = win_row_q;
    o_win_col   = win_col_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        row_d   = '0;
        col_d   = '0;
        state_d = abort_eff ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (abort_eff) begin
          state_d = S_IDLE;
        end else if (accept) begin
          // Window flags refer to the pixel just shifted in, so they trail by one cycle.
          win_valid_d = in_window;
          if (in_window) begin
            win_row_d = row_q - RW'(K - 1);
            win_col_d = col_q - CW'(K - 1);
          end
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d   = '0;
              state_d = S_DONE;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef CONV_WIN_CTRL_ERR_EN
    err_d = err_q;
    if ((state_q == S_IDLE) && i_start) begin
      err_d = 1'b0;
    end else if ((state_q != S_IDLE) && (state_q != S_RUN) && i_pix_valid) begin
      err_d = 1'b1;
    end
    o_err = err_q;
`endif
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_valid_q <= win_valid_d;
    end
  end

`ifdef CONV_WIN_CTRL_ERR_EN
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

endmodule
